rx_cmd_ctrl: RTL

Command sequencer between the UART receiver's byte output and the register file, ALU and UART transmitter. Parses framed command bytes, issues RF writes and reads and ALU operations, and returns results as bytes to the transmitter. Owns the ALU clock-gate enable.

---
 rtl/rx_cmd_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/rx_cmd_ctrl.sv
// rx_cmd_ctrl: command sequencer between the UART receiver and the register
// file, ALU and UART transmitter. Decodes framed command bytes, issues RF
// writes/reads and ALU operations, and streams results back out as bytes.
module rx_cmd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST_n,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RF_RdData,
  input  logic                    RF_RdData_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    TX_BUSY,
  output logic [ADDR_WIDTH-1:0]   RF_Address,
  output logic                    RF_WrEn,
  output logic                    RF_RdEn,
  output logic [DATA_WIDTH-1:0]   RF_WrData,
  output logic                    ALU_EN,
  output logic [FUN_WIDTH-1:0]    ALU_FUN,
  output logic                    CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] CMD_RF_WR   = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RF_RD   = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT,
    OP_A, OP_B, FUN, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                  state_q, state_d;
  logic                    tx_hold_q, tx_hold_d;   // byte presented, waiting for TX_BUSY
  logic                    single_q, single_d;     // result is one byte (RF read)
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;

  logic [ADDR_WIDTH-1:0]   rf_address_d;
  logic                    rf_wr_en_d, rf_rd_en_d;
  logic [DATA_WIDTH-1:0]   rf_wr_data_d;
  logic                    alu_en_d, clk_gate_en_d;
  logic [FUN_WIDTH-1:0]    alu_fun_d;
  logic [DATA_WIDTH-1:0]   tx_p_data_d;
  logic                    tx_d_vld_d;
  logic [DATA_WIDTH-1:0]   tx_byte;

  assign tx_byte = (state_q == TX_LO) ? result_q[DATA_WIDTH-1:0]
                                      : result_q[2*DATA_WIDTH-1:DATA_WIDTH];

  // Next-state and next-output decode for the command sequencer.
  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    tx_hold_d     = tx_hold_q;
    single_d      = single_q;
    addr_d        = addr_q;
    result_d      = result_q;
    rf_address_d  = RF_Address;
    rf_wr_en_d    = 1'b0;
    rf_rd_en_d    = 1'b0;
    rf_wr_data_d  = RF_WrData;
    alu_en_d      = ALU_EN;
    alu_fun_d     = ALU_FUN;
    clk_gate_en_d = CLK_GATE_EN;
    tx_p_data_d   = TX_P_DATA;
    tx_d_vld_d    = TX_D_VLD;

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            CMD_RF_WR:   state_d = WR_ADDR;
            CMD_RF_RD:   state_d = RD_ADDR;
            CMD_ALU_OP:  state_d = OP_A;
            CMD_ALU_NOP: state_d = FUN;
            default:     state_d = IDLE;
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          rf_address_d = addr_q;
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          rf_address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          rf_rd_en_d   = 1'b1;
          state_d      = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Read data wins over any RX byte arriving in the same cycle.
        if (RF_RdData_VLD) begin
          result_d = {{DATA_WIDTH{1'b0}}, RF_RdData};
          single_d = 1'b1;
          state_d  = TX_LO;
          // Present the byte straight away when the transmitter is free.
          tx_hold_d = !TX_BUSY;
          if (!TX_BUSY) begin
            tx_p_data_d = RF_RdData;
            tx_d_vld_d  = 1'b1;
          end
        end
      end
      OP_A: begin
        if (RX_D_VLD) begin
          rf_address_d = '0;
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = OP_B;
        end
      end
      OP_B: begin
        if (RX_D_VLD) begin
          rf_address_d = ADDR_WIDTH'(1);
          rf_wr_data_d = RX_P_DATA;
          rf_wr_en_d   = 1'b1;
          state_d      = FUN;
        end
      end
      FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d     = RX_P_DATA[FUN_WIDTH-1:0];
          clk_gate_en_d = 1'b1;
          state_d       = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (ALU_OUT_VLD) begin
          alu_en_d      = 1'b0;
          clk_gate_en_d = 1'b0;
          result_d      = ALU_OUT;
          single_d      = 1'b0;
          state_d       = TX_LO;
          tx_hold_d     = !TX_BUSY;
          if (!TX_BUSY) begin
            tx_p_data_d = ALU_OUT[DATA_WIDTH-1:0];
            tx_d_vld_d  = 1'b1;
          end
        end else begin
          // The clock gate opens one cycle ahead of the enable.
          alu_en_d = 1'b1;
        end
      end
      TX_LO, TX_HI: begin
        if (!tx_hold_q) begin
          if (!TX_BUSY) begin
            tx_p_data_d = tx_byte;
            tx_d_vld_d  = 1'b1;
            tx_hold_d   = 1'b1;
          end
        end else if (TX_BUSY) begin
          tx_d_vld_d = 1'b0;
          tx_hold_d  = 1'b0;
          state_d    = (state_q == TX_LO && !single_q) ? TX_HI : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, captured data and registered outputs.
  always_ff @(posedge CLK or negedge RST_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!RST_n) begin
      state_q     <= IDLE;
      tx_hold_q   <= 1'b0;
      single_q    <= 1'b0;
      addr_q      <= '0;
      result_q    <= '0;
      RF_Address  <= '0;
      RF_WrEn     <= 1'b0;
      RF_RdEn     <= 1'b0;
      RF_WrData   <= '0;
      ALU_EN      <= 1'b0;
      ALU_FUN     <= '0;
      CLK_GATE_EN <= 1'b0;
      TX_P_DATA   <= '0;
      TX_D_VLD    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_hold_q   <= tx_hold_d;
      single_q    <= single_d;
      addr_q      <= addr_d;
      result_q    <= result_d;
      RF_Address  <= rf_address_d;
      RF_WrEn     <= rf_wr_en_d;
      RF_RdEn     <= rf_rd_en_d;
      RF_WrData   <= rf_wr_data_d;
      ALU_EN      <= alu_en_d;
      ALU_FUN     <= alu_fun_d;
      CLK_GATE_EN <= clk_gate_en_d;
      TX_P_DATA   <= tx_p_data_d;
      TX_D_VLD    <= tx_d_vld_d;
    end
  end

endmodule
